// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins; multi-cycle results queue
// in a small FIFO, drain on idle cycles, and force a one-cycle stall if starved too long.
module rf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] pipe_w,
    input  logic [37:0] mdu_w,
    output logic        mdu_ready,
    output logic [37:0] w,
    output logic        stall,
    output logic [31:0] pend_mask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;
    logic             r_stall;
    logic             r_w_wen;
    logic [4:0]       r_w_addr;
    logic [31:0]      r_w_wd;

    logic             w_pipe_wen;
    logic [4:0]       w_pipe_addr;
    logic [31:0]      w_pipe_wd;
    logic             w_mdu_wen;
    logic [4:0]       w_mdu_addr;
    logic [31:0]      w_mdu_wd;
    logic             w_pipe_go;
    logic             w_pop;
    logic             w_push;
    logic [31:0]      w_pend;

    assign {w_pipe_wen, w_pipe_addr, w_pipe_wd} = pipe_w;
    assign {w_mdu_wen, w_mdu_addr, w_mdu_wd}    = mdu_w;

    // Writes to r0 are accepted and dropped on both inputs.
    assign mdu_ready = (r_count < CW'(DEPTH));
    assign w_pipe_go = !r_stall && w_pipe_wen && (w_pipe_addr != 5'd0);
    assign w_pop     = !w_pipe_go && (r_count != '0);
    assign w_push    = w_mdu_wen && mdu_ready && (w_mdu_addr != 5'd0);

    assign w         = {r_w_wen, r_w_addr, r_w_wd};
    assign stall     = r_stall;
    assign pend_mask = w_pend;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wp] <= w_mdu_addr;
            r_data[r_wp] <= w_mdu_wd;
        end
    end

    // A granted pipeline write kills every queued write to the same register,
    // including one entering the FIFO this very cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pop && (PW'(i) == r_rp)) begin
                    r_live[i] <= 1'b0;
                end else if (w_push && (PW'(i) == r_wp)) begin
                    r_live[i] <= !(w_pipe_go && (w_mdu_addr == w_pipe_addr));
                end else if (w_pipe_go && (r_addr[i] == w_pipe_addr)) begin
                    r_live[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Stall fires after STARVE_LIMIT consecutive ungranted cycles; the stall cycle pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else if (w_pop || (r_count == '0)) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_starve <= r_starve + 1'b1;
            r_stall  <= (r_starve == SW'(STARVE_LIMIT - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w_wen  <= 1'b0;
            r_w_addr <= 5'd0;
            r_w_wd   <= 32'd0;
        end else if (w_pipe_go) begin
            r_w_wen  <= 1'b1;
            r_w_addr <= w_pipe_addr;
            r_w_wd   <= w_pipe_wd;
        end else if (w_pop && r_live[r_rp]) begin
            r_w_wen  <= 1'b1;
            r_w_addr <= r_addr[r_rp];
            r_w_wd   <= r_data[r_rp];
        end else begin
            r_w_wen  <= 1'b0;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i]) w_pend[r_addr[i]] = 1'b1;
        end
        if (r_w_wen) w_pend[r_w_addr] = 1'b1;
        w_pend[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_rf_wb_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        reset;
    logic [37:0] pipe_w;
    logic [37:0] mdu_w;
    logic        mdu_ready;
    logic [37:0] w;
    logic        stall;
    logic [31:0] pend_mask;

    int n_vec = 0;
    int n_bad = 0;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset), .pipe_w(pipe_w), .mdu_w(mdu_w),
        .mdu_ready(mdu_ready), .w(w), .stall(stall), .pend_mask(pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] rfw(input logic wen, input logic [4:0] a, input logic [31:0] d);
        return {wen, a, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs away from the edge, then step past the next rising edge.
    task automatic cyc(input logic [37:0] pw, input logic [37:0] mw);
        @(negedge clk);
        pipe_w = pw;
        mdu_w  = mw;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [37:0] pw;
        logic [37:0] mw;
        logic [37:0] ew;
        logic [31:0] ep;
    } vec_t;

    function automatic vec_t mkv(input logic [37:0] pw, input logic [37:0] mw,
                                 input logic [37:0] ew, input logic [31:0] ep);
        vec_t v;
        v.pw = pw; v.mw = mw; v.ew = ew; v.ep = ep;
        return v;
    endfunction

    // Reference model: FIFO as a queue of pending writes, plus the visible port state.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        live;
    } ent_t;

    ent_t        mq[$];
    logic [37:0] m_w;
    logic        m_stall;
    int          m_wait;

    task automatic model_reset();
        mq.delete();
        m_w     = '0;
        m_stall = 1'b0;
        m_wait  = 0;
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) if (mq[i].live) p[mq[i].a] = 1'b1;
        if (m_w[37]) p[m_w[36:32]] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_step(input logic [37:0] pw, input logic [37:0] mw);
        bit   go, pop, push, nstall;
        ent_t h, e;
        go   = !m_stall && pw[37] && (pw[36:32] != 5'd0);
        pop  = !go && (mq.size() > 0);
        push = mw[37] && (mq.size() < DEPTH) && (mw[36:32] != 5'd0);
        if (mq.size() == 0 || pop) begin
            m_wait = 0;
            nstall = 1'b0;
        end else begin
            m_wait++;
            nstall = (m_wait == STARVE_LIMIT);
        end
        if (go) begin
            m_w = pw;
            foreach (mq[i]) if (mq[i].a == pw[36:32]) mq[i].live = 1'b0;
        end else if (pop) begin
            h = mq.pop_front();
            if (h.live) m_w = {1'b1, h.a, h.d};
            else        m_w[37] = 1'b0;
        end else begin
            m_w[37] = 1'b0;
        end
        if (push) begin
            e.a    = mw[36:32];
            e.d    = mw[31:0];
            e.live = !(go && (mw[36:32] == pw[36:32]));
            mq.push_back(e);
        end
        m_stall = nstall;
    endtask

    vec_t tbl[14];

    initial begin
        logic [37:0] pw, mw, ew;
        logic [37:0] va, vb, vc;

        reset  = 1'b1;
        pipe_w = rfw(1'b1, 5'd5, 32'h55);
        mdu_w  = rfw(1'b1, 5'd6, 32'h66);

        // Reset held for 3 cycles with active inputs, then released.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_wen", w[37], 0);
            check("rst_stall", stall, 0);
            check("rst_pend", pend_mask, 0);
            check("rst_ready", mdu_ready, 1);
        end
        @(negedge clk);
        reset  = 1'b0;
        pipe_w = '0;
        mdu_w  = '0;
        @(posedge clk); #1;
        check("idle_w", w, 0);
        check("idle_pend", pend_mask, 0);
        check("idle_ready", mdu_ready, 1);

        tbl[0]  = mkv(rfw(1, 5, 32'h11), rfw(1, 7, 32'h22), rfw(1, 5, 32'h11), 32'h0000_00A0);
        tbl[1]  = mkv(rfw(1, 5, 32'h11), '0,                 rfw(1, 5, 32'h11), 32'h0000_00A0);
        tbl[2]  = mkv('0,                 '0,                 rfw(1, 7, 32'h22), 32'h0000_0080);
        tbl[3]  = mkv('0,                 '0,                 rfw(0, 7, 32'h22), 32'h0);
        tbl[4]  = mkv('0,                 rfw(1, 4, 32'hAA), rfw(0, 7, 32'h22), 32'h0000_0010);
        tbl[5]  = mkv(rfw(1, 4, 32'hBB), '0,                 rfw(1, 4, 32'hBB), 32'h0000_0010);
        tbl[6]  = mkv('0,                 '0,                 rfw(0, 4, 32'hBB), 32'h0);
        tbl[7]  = mkv(rfw(1, 6, 32'h66), rfw(1, 6, 32'h77), rfw(1, 6, 32'h66), 32'h0000_0040);
        tbl[8]  = mkv('0,                 '0,                 rfw(0, 6, 32'h66), 32'h0);
        tbl[9]  = mkv(rfw(1, 0, 32'hFF), rfw(1, 0, 32'hEE), rfw(0, 6, 32'h66), 32'h0);
        tbl[10] = mkv('0,                 '0,                 rfw(0, 6, 32'h66), 32'h0);
        tbl[11] = mkv('0,                 rfw(1, 3, 32'h33), rfw(0, 6, 32'h66), 32'h0000_0008);
        tbl[12] = mkv(rfw(1, 0, 32'hFF), '0,                 rfw(1, 3, 32'h33), 32'h0000_0008);
        tbl[13] = mkv('0,                 '0,                 rfw(0, 3, 32'h33), 32'h0);

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].pw, tbl[i].mw);
            check($sformatf("tbl%0d_w", i), w, tbl[i].ew);
            check($sformatf("tbl%0d_pend", i), pend_mask, tbl[i].ep);
            check($sformatf("tbl%0d_stall", i), stall, 0);
            check($sformatf("tbl%0d_ready", i), mdu_ready, 1);
        end

        // Starvation: pipe busy every cycle, one queued result.
        for (int k = 0; k < 8; k++) begin
            cyc(rfw(1, 1, 32'(k)), (k == 0) ? rfw(1, 9, 32'h33) : 38'd0);
            ew = (k == 5) ? rfw(1, 9, 32'h33) : rfw(1, 1, 32'(k));
            check($sformatf("starve%0d_stall", k), stall, (k == 4));
            check($sformatf("starve%0d_w", k), w, ew);
            check($sformatf("starve%0d_pend9", k), pend_mask[9], (k <= 5));
        end
        cyc('0, '0);

        // Full FIFO: third push waits until the cycle after the first pop.
        va = rfw(1, 10, 32'hA0);
        vb = rfw(1, 11, 32'hA1);
        vc = rfw(1, 12, 32'hA2);
        for (int t = 0; t < 9; t++) begin
            pw = (t <= 5) ? rfw(1, 1, 32'h40 + 32'(t)) : 38'd0;
            mw = (t == 0) ? va : (t == 1) ? vb : (t <= 6) ? vc : 38'd0;
            @(negedge clk);
            pipe_w = pw;
            mdu_w  = mw;
            check($sformatf("full%0d_ready", t), mdu_ready, !(t >= 2 && t <= 5));
            @(posedge clk); #1;
            case (t)
                5:       ew = va;
                6:       ew = vb;
                7:       ew = vc;
                8:       ew = rfw(0, 12, 32'hA2);
                default: ew = pw;
            endcase
            check($sformatf("full%0d_w", t), w, ew);
            check($sformatf("full%0d_stall", t), stall, (t == 4));
        end

        // Back-to-back push/pop pairs walk the pointers around the ring.
        for (int i = 0; i < 11; i++) begin
            cyc('0, (i < 10) ? rfw(1, 5'(16 + i % 8), 32'h1000 + 32'(i)) : 38'd0);
            check($sformatf("pair%0d_ready", i), mdu_ready, 1);
            if (i == 0) check("pair0_wen", w[37], 0);
            else check($sformatf("pair%0d_w", i), w,
                       rfw(1, 5'(16 + (i - 1) % 8), 32'h1000 + 32'(i - 1)));
        end

        // Randomized traffic against the reference model.
        @(negedge clk);
        reset = 1'b1;
        pipe_w = '0;
        mdu_w  = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            check("rnd_w", w, m_w);
            check("rnd_stall", stall, m_stall);
            check("rnd_pend", pend_mask, model_pend());
            check("rnd_ready", mdu_ready, (mq.size() < DEPTH));
            pw = rfw(($urandom_range(0, 99) < 65), 5'($urandom_range(0, 7)), $urandom);
            mw = rfw(($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
            pipe_w = pw;
            mdu_w  = mw;
            model_step(pw, mw);
        end

        // Mid-operation reset clears the port and the queue without waiting for a clock.
        cyc(rfw(1, 2, 32'h5), rfw(1, 3, 32'h6));
        check("mid_pre_wen", w[37], 1);
        check("mid_pre_pend3", pend_mask[3], 1);
        pipe_w = '0;
        mdu_w  = '0;
        #2;
        reset = 1'b1;
        #1;
        check("mid_wen", w[37], 0);
        check("mid_stall", stall, 0);
        check("mid_pend", pend_mask, 0);
        check("mid_ready", mdu_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc('0, '0);
            check("post_rst_wen", w[37], 0);
            check("post_rst_pend", pend_mask, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and the multi-cycle unit (mult/div, late CP0/load returns). Pipeline writes always win. Multi-cycle results queue in a small FIFO and drain on idle port cycles. A starvation guard forces a one-cycle pipeline stall when needed, and a pending-address mask lets the hazard unit interlock on queued writes.

## Interface
- DEPTH, 2, FIFO entries for multi-cycle results (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go ungranted before a stall is forced (≥1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pipe_w  in  rf_w_t  pipeline writeback {wen, addr[4:0], wd[31:0]}; wen is valid, no backpressure
- mdu_w  in  rf_w_t  multi-cycle result; wen is valid
- mdu_ready  out  1  FIFO can accept mdu_w this cycle
- w  out  rf_w_t  registered write port driven into the regfile
- stall  out  1  registered; pipeline must freeze writeback for this cycle
- pend_mask  out  32  bit a set = a write to register a is queued or in the output register

## Operation
- Zero-address filter: any pipe_w or mdu_w with addr==0 is accepted and discarded. It is never queued, never sets pend_mask, and never drives w.wen.
- Push: mdu_w.wen && mdu_ready enqueues {addr, wd, live=1}. mdu_ready = (count < DEPTH), derived from registered count only. No same-cycle pop credit.
- Grant priority, per cycle:
  - If stall is low and pipe_w.wen, with addr≠0, pipe_w wins.
  - Else, if the FIFO is non-empty, the head is popped.
  - Else the port is idle.
- Squash: when a pipe_w write to addr A is granted, every live FIFO entry with addr A is marked live=0. This includes an entry pushed in the same cycle. The younger pipeline write wins.
- Popping a dead head consumes the grant but drives w.wen=0.
- Output register: the winner's {addr, wd} load into w with w.wen=1. Otherwise w.wen=0, and w.addr/w.wd hold their previous values.
- Starvation counter (starve_cnt):
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on pop or when the FIFO becomes empty.
  - When starve_cnt reaches STARVE_LIMIT−1 while incrementing, stall is set for exactly the next cycle.
- Stall cycle:
  - pipe_w is ignored; the pipeline re-presents it next cycle.
  - The head is popped and starve_cnt clears.
  - stall deasserts after one cycle; it never stays high for two consecutive cycles.
- pend_mask: OR over live FIFO entries of onehot(addr), OR onehot(w.addr) when w.wen. Bit 0 is always 0. Combinational from state.
- Simultaneous push and pop are allowed: count is unchanged and pointers advance independently, wrapping modulo DEPTH.

## Timing
- Reset values: w.wen=0, w.addr=0, w.wd=0, stall=0, count=0, starve_cnt=0, all live=0, pend_mask=0. mdu_ready=1 while reset is high.
- Latency:
  - pipe_w at cycle N appears on w at N+1.
  - An mdu_w pushed into an empty FIFO at N, with pipe idle at N+1, is popped at N+1 and appears on w at N+2.
  - The FIFO is never bypassed.
- Worst-case wait for the head: STARVE_LIMIT cycles of pipeline writes, then a stall cycle.
- A full FIFO holds mdu_ready low until the cycle after a pop.
- Reset asserted mid-operation drops all queued entries immediately. w.wen and stall go low asynchronously.

## Test plan
- Reset/idle:
  - Stimulus: assert reset for 3 cycles, then release.
  - Required: w.wen=0, stall=0, pend_mask=0, mdu_ready=1 throughout.
- Priority:
  - Stimulus: pipe_w {r5, 0x11} every cycle for 2 cycles, with mdu_w {r7, 0x22} pushed at cycle 0.
  - Required: w shows r5 at cycles 1 and 2, then r7/0x22 at cycle 3. pend_mask[7]=1 from cycle 1 through cycle 3.
- Starvation (STARVE_LIMIT=4):
  - Stimulus: pipe_w active every cycle; mdu_w {r9, 0x33} pushed at cycle 0.
  - Required: stall=1 only at cycle 5. r9 is written at cycle 6. The pipe_w presented at cycle 5 is not written that cycle.
- Squash:
  - Stimulus: queue {r4, 0xAA}, then at the next cycle pipe_w {r4, 0xBB}.
  - Required: exactly one regfile write to r4 (0xBB). The dead head pops with w.wen=0, and pend_mask[4] clears.
- Full/wrap (DEPTH=2):
  - Stimulus: push 3 entries back-to-back while the pipe is busy.
  - Required: mdu_ready=0 after 2 pushes; the third is accepted only after the first pop. Run 10 push/pop pairs and check in-order data.
- Zero address:
  - Stimulus: pipe_w {r0, 0xFF} and mdu_w {r0, 0xEE}.
  - Required: w.wen never 1, FIFO count stays 0, pend_mask[0]=0.
